// File: rtl/fu_commit_unit_if.sv
// Issue, result and commit signals between the controller, the functional units and the commit unit.
interface fu_commit_unit_if;
  logic        issue_valid;
  logic [2:0]  issue_fu;
  logic [4:0]  issue_rd;
  logic        issue_we;
  logic        issue_ready;
  logic [4:0]  fu_done;
  logic [31:0] ALU_res;
  logic [31:0] MEM_res;
  logic [31:0] MUL_res;
  logic [31:0] DIV_res;
  logic [31:0] JUMP_res;
  logic [4:0]  fu_busy;
  logic [2:0]  write_sel;
  logic [4:0]  rd_ctrl;
  logic        reg_write;
  logic [31:0] wb_data;
  logic        err;

  modport master (
    output issue_valid, issue_fu, issue_rd, issue_we, fu_done,
    output ALU_res, MEM_res, MUL_res, DIV_res, JUMP_res,
    input  issue_ready, fu_busy, write_sel, rd_ctrl, reg_write, wb_data, err
  );

  modport slave (
    input  issue_valid, issue_fu, issue_rd, issue_we, fu_done,
    input  ALU_res, MEM_res, MUL_res, DIV_res, JUMP_res,
    output issue_ready, fu_busy, write_sel, rd_ctrl, reg_write, wb_data, err
  );
endinterface

// File: rtl/fu_commit_unit.sv
// In-order commit unit: tracks issued ops in a FIFO, buffers out-of-order FU results,
// and retires at most one op per cycle in issue order with registered write-back outputs.
module fu_commit_unit #(
  parameter int unsigned DEPTH = 8
) (
  input logic              clk,
  input logic              rst,
  fu_commit_unit_if.slave  bus
);
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned NFU = 5;

  typedef struct packed {
    logic [2:0] fu;
    logic [4:0] rd;
    logic       we;
  } entry_t;

  entry_t            q [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;
  logic [31:0]       rbuf [NFU];
  logic [NFU-1:0]    rvld;
  logic [NFU-1:0]    busy;
  logic [31:0]       res [NFU];

  logic              legal_c;
  logic [NFU-1:0]    issue_oh_c;
  logic              issue_ready_c;
  logic              issue_go_c;
  entry_t            head_e_c;
  logic [2:0]        head_idx_c;
  logic [NFU-1:0]    head_oh_c;
  logic              commit_c;
  logic [NFU-1:0]    commit_oh_c;
  logic [NFU-1:0]    cap_c;
  logic              err_set_c;

  assign res[0] = bus.ALU_res;
  assign res[1] = bus.MEM_res;
  assign res[2] = bus.MUL_res;
  assign res[3] = bus.DIV_res;
  assign res[4] = bus.JUMP_res;

  assign bus.fu_busy     = busy;
  assign bus.issue_ready = issue_ready_c;

  // Issue acceptance, commit selection and result capture, all from registered state.
  always_comb begin
    legal_c       = (bus.issue_fu >= 3'd1) && (bus.issue_fu <= 3'd5);
    issue_oh_c    = legal_c ? (NFU'(1) << (bus.issue_fu - 3'd1)) : '0;
    issue_ready_c = (count < CW'(DEPTH)) && legal_c && ((issue_oh_c & busy) == '0);
    issue_go_c    = bus.issue_valid && issue_ready_c;

    head_e_c      = q[head];
    head_idx_c    = head_e_c.fu - 3'd1;
    head_oh_c     = NFU'(1) << head_idx_c;
    commit_c      = (count != '0) && ((head_oh_c & rvld) != '0);
    commit_oh_c   = commit_c ? head_oh_c : '0;

    cap_c         = bus.fu_done & busy & ~rvld;
    err_set_c     = ((bus.fu_done & ~cap_c) != '0) || (bus.issue_valid && !legal_c);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      rvld          <= '0;
      busy          <= '0;
      bus.err       <= 1'b0;
      bus.write_sel <= '0;
      bus.rd_ctrl   <= '0;
      bus.reg_write <= 1'b0;
      bus.wb_data   <= '0;
    end else begin
      if (issue_go_c) tail <= tail + PW'(1);
      if (commit_c)   head <= head + PW'(1);
      count   <= count + CW'(issue_go_c) - CW'(commit_c);
      busy    <= (busy & ~commit_oh_c) | (issue_go_c ? issue_oh_c : '0);
      rvld    <= (rvld & ~commit_oh_c) | cap_c;
      bus.err <= bus.err | err_set_c;
      // Write-back is presented one cycle after the commit decision.
      bus.write_sel <= commit_c ? head_e_c.fu : '0;
      bus.rd_ctrl   <= commit_c ? head_e_c.rd : '0;
      bus.reg_write <= commit_c && head_e_c.we && (head_e_c.rd != '0);
      bus.wb_data   <= commit_c ? rbuf[head_idx_c] : '0;
    end
  end

  // Payload storage; validity lives in count/rvld, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (issue_go_c) q[tail] <= '{fu: bus.issue_fu, rd: bus.issue_rd, we: bus.issue_we};
    for (int k = 0; k < NFU; k++) begin
      if (cap_c[k]) rbuf[k] <= res[k];
    end
  end
endmodule

// File: tb/tb_fu_commit_unit.sv
// Randomized and directed scoreboard bench for fu_commit_unit against a queue-based reference model.
module tb_fu_commit_unit;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fu_commit_unit_if bus();
  fu_commit_unit #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {int fu; int rd; bit we;} op_t;
  typedef struct {int cyc; int fu; int rd; logic [31:0] data; bit wr;} exp_t;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          chk_en = 0;
  op_t         mq[$];
  exp_t        exp_q[$];
  bit          m_busy[6];
  bit          m_vld[6];
  logic [31:0] m_data[6];
  bit          m_err = 0;
  logic [31:0] res_s[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  function automatic bit m_legal(int f);
    return (f >= 1) && (f <= 5);
  endfunction

  function automatic bit m_ready(int f);
    return (mq.size() < int'(DEPTH)) && m_legal(f) && !m_busy[f];
  endfunction

  function automatic logic [4:0] m_busy_vec();
    logic [4:0] v = '0;
    for (int k = 1; k <= 5; k++) v[k-1] = m_busy[k];
    return v;
  endfunction

  // One clock of the reference model: ops retire in issue order once their FU result is held.
  task automatic m_step(input bit r, input bit v, input int f, input int rd, input bit we,
                        input logic [4:0] done);
    bit  rdy;
    int  cfu;
    op_t h;
    if (r) begin
      mq.delete();
      for (int k = 0; k < 6; k++) begin m_busy[k] = 0; m_vld[k] = 0; end
      m_err = 0;
      return;
    end
    rdy = m_ready(f);
    cfu = 0;
    if (mq.size() > 0 && m_vld[mq[0].fu]) begin
      h = mq.pop_front();
      exp_q.push_back('{cyc + 1, h.fu, h.rd, m_data[h.fu], h.we && (h.rd != 0)});
      cfu = h.fu;
    end
    for (int k = 1; k <= 5; k++) begin
      if (done[k-1]) begin
        if (m_busy[k] && !m_vld[k]) begin m_vld[k] = 1; m_data[k] = res_s[k-1]; end
        else m_err = 1;
      end
    end
    if (cfu != 0) begin m_vld[cfu] = 0; m_busy[cfu] = 0; end
    if (v) begin
      if (rdy) begin mq.push_back('{f, rd, we}); m_busy[f] = 1; end
      else if (!m_legal(f)) m_err = 1;
    end
  endtask

  task automatic tick(input bit r, input bit v, input int f, input int rd, input bit we,
                      input logic [4:0] done, input logic [31:0] dv);
    @(posedge clk);
    cyc++;
    #1;
    if (chk_en) begin
      chk("err", 32'(bus.err), 32'(m_err));
      chk("fu_busy", 32'(bus.fu_busy), 32'(m_busy_vec()));
    end
    rst             = r;
    bus.issue_valid = v;
    bus.issue_fu    = 3'(f);
    bus.issue_rd    = 5'(rd);
    bus.issue_we    = we;
    bus.fu_done     = done;
    for (int k = 0; k < 5; k++) res_s[k] = done[k] ? dv + 32'(k) : $urandom;
    bus.ALU_res  = res_s[0];
    bus.MEM_res  = res_s[1];
    bus.MUL_res  = res_s[2];
    bus.DIV_res  = res_s[3];
    bus.JUMP_res = res_s[4];
    #1;
    if (chk_en) chk("issue_ready", 32'(bus.issue_ready), 32'(m_ready(f)));
    m_step(r, v, f, rd, we, done);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 0, 0, 5'b0, 32'h0);
  endtask

  task automatic issue(input int f, input int rd, input bit we);
    tick(0, 1, f, rd, we, 5'b0, 32'h0);
  endtask

  task automatic do_reset();
    tick(1, 0, 0, 0, 0, 5'b0, 32'h0);
  endtask

  // Commit-side monitor: every cycle is either an expected commit or an idle zero output.
  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("commit_missed", 32'(cyc), 32'(exp_q[0].cyc));
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        chk("write_sel", 32'(bus.write_sel), 32'(e.fu));
        chk("rd_ctrl", 32'(bus.rd_ctrl), 32'(e.rd));
        chk("wb_data", bus.wb_data, e.data);
        chk("reg_write", 32'(bus.reg_write), 32'(e.wr));
      end else begin
        chk("idle_sel_rd_we", 32'({bus.write_sel, bus.rd_ctrl, bus.reg_write}), 32'h0);
        chk("idle_wb_data", bus.wb_data, 32'h0);
      end
    end
  end

  initial begin
    logic [4:0] done;
    int         f;
    bus.issue_valid = 0; bus.issue_fu = 0; bus.issue_rd = 0; bus.issue_we = 0;
    bus.fu_done = 0;
    bus.ALU_res = 0; bus.MEM_res = 0; bus.MUL_res = 0; bus.DIV_res = 0; bus.JUMP_res = 0;
    do_reset();
    do_reset();
    chk_en = 1;

    // Single op with a fixed result value.
    issue(1, 5, 1);
    idle(1);
    tick(0, 0, 0, 0, 0, 5'b00001, 32'h1234);
    idle(4);

    // Out-of-order completion, in-order commit.
    issue(4, 3, 1);
    issue(1, 4, 1);
    tick(0, 0, 0, 0, 0, 5'b00001, 32'hA1A1_0000);
    idle(20);
    tick(0, 0, 0, 0, 0, 5'b01000, 32'hD1D1_0000);
    idle(4);

    // Structural hazard on MUL.
    issue(3, 7, 1);
    issue(3, 8, 1);
    tick(0, 0, 0, 0, 0, 5'b00100, 32'h3333_0000);
    idle(4);

    // Fill the queue, JUMP refused until ALU retires.
    issue(1, 1, 1);
    issue(2, 2, 1);
    issue(3, 3, 1);
    issue(4, 4, 1);
    issue(5, 6, 1);
    tick(0, 1, 5, 6, 1, 5'b00001, 32'h0A0A_0000);
    issue(5, 6, 1);
    issue(5, 6, 1);
    issue(5, 6, 1);
    tick(0, 0, 0, 0, 0, 5'b11110, 32'h5555_0000);
    idle(6);

    // Protocol errors and an rd=0 commit.
    do_reset();
    issue(6, 9, 1);
    idle(2);
    do_reset();
    tick(0, 0, 0, 0, 0, 5'b00100, 32'h0);
    idle(2);
    do_reset();
    issue(1, 0, 1);
    tick(0, 0, 0, 0, 0, 5'b00001, 32'hBEEF_0000);
    idle(3);

    // Reset abandons a pending DIV with a buffered ALU behind it.
    issue(4, 9, 1);
    issue(1, 10, 1);
    tick(0, 0, 0, 0, 0, 5'b00001, 32'hCAFE_0000);
    idle(1);
    do_reset();
    idle(1);
    tick(0, 0, 0, 0, 0, 5'b01000, 32'hDEAD_0000);
    idle(2);
    do_reset();

    // Randomized traffic including illegal issues, stray dones and resets.
    for (int i = 0; i < 3000; i++) begin
      done = '0;
      for (int k = 0; k < 5; k++) begin
        if (m_busy[k+1] && !m_vld[k+1] && $urandom_range(0, 2) == 0) done[k] = 1'b1;
        else if ($urandom_range(0, 199) == 0) done[k] = 1'b1;
      end
      if ($urandom_range(0, 9) == 0) f = ($urandom_range(0, 2) == 0) ? 0 : 6 + int'($urandom_range(0, 1));
      else f = int'($urandom_range(1, 5));
      tick($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), f, int'($urandom_range(0, 31)),
           1'($urandom_range(0, 1)), done, $urandom);
    end

    // Drain everything still in flight.
    for (int i = 0; i < 40; i++) begin
      done = '0;
      for (int k = 0; k < 5; k++) done[k] = m_busy[k+1] && !m_vld[k+1];
      tick(0, 0, 0, 0, 0, done, $urandom);
    end
    idle(3);
    chk("drain_pending_ops", 32'(mq.size()), 32'h0);
    chk("drain_expected_commits", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
